// File: rtl/systolic_ctrl.sv
// systolic_ctrl: sequences one systolic-array job of tile_num tiles.
// Issues SRAM reads (one prefetch plus one per run cycle), drives the array
// enable/cycle count, and marks which output diagonal is valid each cycle.
// A valid diagonal that the consumer refuses (out_ready=0) freezes the whole
// pipeline for that cycle.
//
// Ports:
//   clk, srstn         clock, synchronous active-low reset
//   start              job request, honoured only in IDLE
//   tile_num           tiles in the job (0 = empty job, straight to DONE)
//   w_base, d_base     weight/data SRAM base addresses
//   out_ready          consumer accepts the current diagonal
//   sram_ren           shared SRAM read enable
//   sram_raddr_w/_d    SRAM read addresses
//   alu_start          array enable
//   cycle_num          array cycle count
//   matrix_index       output diagonal select
//   out_valid          output diagonal valid
//   busy               job active (PREFETCH/RUN)
//   done               one-cycle completion pulse
module systolic_ctrl #(
    parameter int unsigned ARRAY_SIZE  = 8,
    parameter int unsigned CYCLE_BITS  = 9,
    parameter int unsigned MATRIX_BITS = 6,
    parameter int unsigned ADDR_BITS   = 10,
    parameter int unsigned TILE_BITS   = 4
) (
    input  logic                   clk,
    input  logic                   srstn,
    input  logic                   start,
    input  logic [TILE_BITS-1:0]   tile_num,
    input  logic [ADDR_BITS-1:0]   w_base,
    input  logic [ADDR_BITS-1:0]   d_base,
    input  logic                   out_ready,
    output logic                   sram_ren,
    output logic [ADDR_BITS-1:0]   sram_raddr_w,
    output logic [ADDR_BITS-1:0]   sram_raddr_d,
    output logic                   alu_start,
    output logic [CYCLE_BITS-1:0]  cycle_num,
    output logic [MATRIX_BITS-1:0] matrix_index,
    output logic                   out_valid,
    output logic                   busy,
    output logic                   done
);

    localparam int unsigned P         = 2 * ARRAY_SIZE;
    localparam int unsigned FIRST_OUT = ARRAY_SIZE + 1;
    localparam int unsigned CW        = CYCLE_BITS + 1;

    typedef enum logic [1:0] {
        StIdle,
        StPrefetch,
        StRun,
        StDone
    } state_e;

    state_e                state_q, state_d;
    logic [CYCLE_BITS-1:0] cycle_q, cycle_d;
    logic [TILE_BITS-1:0]  tile_q, tile_d;
    logic [ADDR_BITS-1:0]  w_base_q, w_base_d;
    logic [ADDR_BITS-1:0]  d_base_q, d_base_d;

    logic [CYCLE_BITS-1:0] last;
    logic [CYCLE_BITS-1:0] phase;
    logic [CW-1:0]         rd_limit;
    logic [CW-1:0]         rd_next;
    logic [ADDR_BITS-1:0]  addr_off;
    logic                  out_win;
    logic                  stall;

    // Job geometry, all derived from captured (registered) values.
    always_comb begin
        last     = CYCLE_BITS'(tile_q) * CYCLE_BITS'(P) + CYCLE_BITS'(ARRAY_SIZE);
        rd_limit = CW'(tile_q) * CW'(P);
        rd_next  = CW'(cycle_q) + CW'(1);
        // Underflows below FIRST_OUT, but out_win masks those cycles.
        phase    = (cycle_q - CYCLE_BITS'(FIRST_OUT)) % CYCLE_BITS'(P);
        out_win  = (state_q == StRun) && (cycle_q >= CYCLE_BITS'(FIRST_OUT)) &&
                   (phase <= CYCLE_BITS'(P - 2));
        stall    = out_win && !out_ready;
        // The prefetch already fetched base, so run cycle c reads base+c+1.
        addr_off = ADDR_BITS'(cycle_q) + ADDR_BITS'(1);
    end

    always_ff @(posedge clk) begin
        if (!srstn) begin
            state_q  <= StIdle;
            cycle_q  <= '0;
            tile_q   <= '0;
            w_base_q <= '0;
            d_base_q <= '0;
        end else begin
            state_q  <= state_d;
            cycle_q  <= cycle_d;
            tile_q   <= tile_d;
            w_base_q <= w_base_d;
            d_base_q <= d_base_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cycle_d      = cycle_q;
        tile_d       = tile_q;
        w_base_d     = w_base_q;
        d_base_d     = d_base_q;
        sram_ren     = 1'b0;
        sram_raddr_w = '0;
        sram_raddr_d = '0;
        alu_start    = 1'b0;
        cycle_num    = '0;
        matrix_index = '0;
        out_valid    = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;

        case (state_q)
            StIdle: begin
                cycle_d = '0;
                if (start) begin
                    if (tile_num != '0) begin
                        tile_d   = tile_num;
                        w_base_d = w_base;
                        d_base_d = d_base;
                        state_d  = StPrefetch;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StPrefetch: begin
                busy         = 1'b1;
                sram_ren     = 1'b1;
                sram_raddr_w = w_base_q;
                sram_raddr_d = d_base_q;
                cycle_d      = '0;
                state_d      = StRun;
            end
            StRun: begin
                busy         = 1'b1;
                cycle_num    = cycle_q;
                sram_raddr_w = w_base_q + addr_off;
                sram_raddr_d = d_base_q + addr_off;
                out_valid    = out_win;
                matrix_index = out_win ? MATRIX_BITS'(phase) : '0;
                // A stalled cycle freezes count, addresses and state.
                if (!stall) begin
                    alu_start = 1'b1;
                    sram_ren  = (rd_next < rd_limit);
                    if (cycle_q == last) begin
                        cycle_d = '0;
                        state_d = StDone;
                    end else begin
                        cycle_d = cycle_q + CYCLE_BITS'(1);
                    end
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule
